uart_baud_gen: RTL
==================

Name: uart_baud_gen

Overview:
Parametrised fractional baud-rate generator for the UART RX and TX paths. A phase-accumulator NCO produces an oversample tick (`os_tick`) for receiver sampling. A divided bit tick (`bit_tick`) drives transmitter shifting. The increment is reloadable at runtime for baud changes, and a `sync` input realigns phase to a detected RX start-bit edge.

Parameters:
ACC_WIDTH, 24, phase accumulator width in bits.
DEFAULT_INC, 24'd25770, increment loaded at reset; equals 2^24 * 16 * 9600 / 100 MHz.
OVERSAMPLE, 16, number of os_ticks per bit_tick; must be >= 2.

Ports:
clk  input  1  clock.
rst  input  1  synchronous, active-high reset.
en  input  1  generator enable; when low, phase and counters hold.
sync  input  1  one-cycle phase restart; clears accumulator and oversample counter.
inc_load  input  1  one-cycle strobe; captures inc_in.
inc_in  input  ACC_WIDTH  new increment value.
os_tick  output  1  one-cycle pulse at the oversample rate.
bit_tick  output  1  one-cycle pulse at the bit rate; always coincident with an os_tick.
mid_tick  output  1  one-cycle mid-bit pulse (optional feature; otherwise tied 0).

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. rst has priority over every other input.
- Reset values: acc=0, osc=0, inc_r=DEFAULT_INC, os_tick=0, bit_tick=0, mid_tick=0.
- Accumulator:
  - Each cycle with en=1 and sync=0: {carry, acc_next} = acc + inc_r, computed at ACC_WIDTH+1 bits; acc <= acc_next; os_tick <= carry.
  - Because inc_r < 2^ACC_WIDTH, at most one carry occurs per cycle.
- Oversample counter: osc has width $clog2(OVERSAMPLE).
  - On carry: osc increments and wraps from OVERSAMPLE-1 to 0.
  - bit_tick <= carry && (osc == OVERSAMPLE-1).
- All outputs are registered. Latency: a tick appears the cycle after the edge at which the carry occurred.
- Long-run rate: os_tick rate = f_clk * inc_r / 2^ACC_WIDTH.
  - Spacing between ticks may jitter by one clock for non-power-of-two ratios.
  - There is no cumulative error.
- en=0: acc and osc hold; os_tick, bit_tick and mid_tick are 0. Phase resumes exactly where it stopped when en returns to 1.
- sync=1: acc <= 0 and osc <= 0; all ticks are 0 that cycle. sync takes priority over en and carry.
  - With en=1, the first os_tick after sync is identical to the first os_tick after reset.
- inc_load=1: inc_r <= inc_in. The new value is used from the following cycle; acc is not disturbed.
  - inc_load has equal priority with sync; when both are asserted, both take effect.
  - inc_load is honoured even when en=0.
- inc_in=0 is legal: the generator stalls with no ticks until a nonzero load.
- rst mid-operation: inc_r reverts to DEFAULT_INC and all state clears on the next edge.

Optional Feature:
Macro UART_BAUD_MIDBIT_EN.
- Defined: mid_tick <= carry && (osc == OVERSAMPLE/2-1), i.e. the centre of the bit; the RX samples here after sync.
  - mid_tick is suppressed under en=0, sync and rst, like the other ticks.
- Undefined: mid_tick is a constant 0 and the comparator logic is absent.

Test Plan:
1. ACC_WIDTH=8, DEFAULT_INC=64, OVERSAMPLE=4; release rst, en=1 -> os_tick every 4th cycle; bit_tick every 16th cycle, coincident with every 4th os_tick; first os_tick 4 cycles after rst drops.
2. Same parameters; inc_load with inc_in=128 mid-stream -> os_tick period becomes 2 from the cycle after the load; bit_tick period 8; no missed or double tick at the transition.
3. Same parameters; pulse sync when osc=2 -> next os_tick 4 cycles later, next bit_tick 16 cycles later; with UART_BAUD_MIDBIT_EN, mid_tick 8 cycles after sync.
4. Same parameters; en=0 for 10 cycles mid-period -> no ticks; after en=1, remaining phase completes with no extra delay beyond the paused cycles.
5. ACC_WIDTH=8, inc=85 over 768 enabled cycles -> exactly 255 os_ticks; spacing only 3 or 4 cycles.
6. Load inc_in=200, then assert rst for 1 cycle -> outputs 0, inc_r=DEFAULT_INC; sync and inc_load asserted together -> both effects observed.

Source files
------------

// File: rtl/uart_baud_gen.sv
// Fractional NCO baud generator: oversample tick from accumulator carry, bit tick every OVERSAMPLE os_ticks.
// Optional mid-bit tick enabled by defining UART_BAUD_MIDBIT_EN; otherwise mid_tick is tied low.
module uart_baud_gen #(
   parameter int          ACC_WIDTH   = 24,
   parameter int unsigned DEFAULT_INC = 25770,
   parameter int          OVERSAMPLE  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 sync,
   input  logic                 inc_load,
   input  logic [ACC_WIDTH-1:0] inc_in,
   output logic                 os_tick,
   output logic                 bit_tick,
   output logic                 mid_tick
);

   localparam int             OSC_W    = $clog2(OVERSAMPLE);
   localparam logic [OSC_W-1:0] OSC_LAST = OSC_W'(OVERSAMPLE - 1);

   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [ACC_WIDTH-1:0] inc_q, inc_d;
   logic [OSC_W-1:0]     osc_q, osc_d;
   logic                 os_q, os_d;
   logic                 bit_q, bit_d;
   logic [ACC_WIDTH:0]   sum;
   logic                 carry;

   // One extra bit holds the carry; inc_q < 2^ACC_WIDTH so at most one wrap per cycle.
   assign sum   = {1'b0, acc_q} + {1'b0, inc_q};
   assign carry = sum[ACC_WIDTH];

   always_comb begin
      acc_d = acc_q;
      inc_d = inc_q;
      osc_d = osc_q;
      os_d  = 1'b0;
      bit_d = 1'b0;
      if (inc_load) begin
         inc_d = inc_in;
      end
      if (sync) begin
         acc_d = '0;
         osc_d = '0;
      end else if (en) begin
         acc_d = sum[ACC_WIDTH-1:0];
         os_d  = carry;
         bit_d = carry && (osc_q == OSC_LAST);
         if (carry) begin
            osc_d = (osc_q == OSC_LAST) ? '0 : osc_q + OSC_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         inc_q <= ACC_WIDTH'(DEFAULT_INC);
         osc_q <= '0;
         os_q  <= 1'b0;
         bit_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         inc_q <= inc_d;
         osc_q <= osc_d;
         os_q  <= os_d;
         bit_q <= bit_d;
      end
   end

   assign os_tick  = os_q;
   assign bit_tick = bit_q;

`ifdef UART_BAUD_MIDBIT_EN
   localparam logic [OSC_W-1:0] OSC_MID = OSC_W'(OVERSAMPLE / 2 - 1);

   logic mid_q, mid_d;

   // Centre of the bit, counted from the last sync.
   always_comb begin
      mid_d = 1'b0;
      if (!sync && en) begin
         mid_d = carry && (osc_q == OSC_MID);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mid_q <= 1'b0;
      end else begin
         mid_q <= mid_d;
      end
   end

   assign mid_tick = mid_q;
`else
   assign mid_tick = 1'b0;
`endif

endmodule
